// File: rtl/line_buffer_window_scheduler_if.sv
// rtl/line_buffer_window_scheduler_if.sv - pixel strobe in; line-buffer write/read and matrix-valid out
// The scheduler takes the master modport; the pixel source and buffer side take the slave modport.
interface line_buffer_window_scheduler_if #(
  parameter int COLUMN_BITS = 10,
  parameter int ROW_BITS    = 9
);
  logic                   I_SOF;
  logic                   I_PIXEL_STROBE;
  logic                   O_WRITE_ENABLE;
  logic [COLUMN_BITS-1:0] O_WRITE_COLUMN;
  logic [1:0]             O_WRITE_SLOT;
  logic                   O_READ_ENABLE;
  logic [COLUMN_BITS-1:0] O_READ_COLUMN;
  logic [1:0]             O_READ_TOP_SLOT;
  logic                   O_MATRIX_VALID;
  logic [COLUMN_BITS-1:0] O_MATRIX_COLUMN;
  logic [ROW_BITS-1:0]    O_MATRIX_ROW;
  logic                   O_FRAME_DONE;
  logic                   O_OVERRUN;

  modport master (
    input  I_SOF, I_PIXEL_STROBE,
    output O_WRITE_ENABLE, O_WRITE_COLUMN, O_WRITE_SLOT,
    output O_READ_ENABLE, O_READ_COLUMN, O_READ_TOP_SLOT,
    output O_MATRIX_VALID, O_MATRIX_COLUMN, O_MATRIX_ROW,
    output O_FRAME_DONE, O_OVERRUN
  );

  modport slave (
    output I_SOF, I_PIXEL_STROBE,
    input  O_WRITE_ENABLE, O_WRITE_COLUMN, O_WRITE_SLOT,
    input  O_READ_ENABLE, O_READ_COLUMN, O_READ_TOP_SLOT,
    input  O_MATRIX_VALID, O_MATRIX_COLUMN, O_MATRIX_ROW,
    input  O_FRAME_DONE, O_OVERRUN
  );
endinterface

// File: rtl/line_buffer_window_scheduler.sv
// rtl/line_buffer_window_scheduler.sv - 3-row line buffer write/read sequencer for the Sobel window
// Tracks frame column/row per pixel strobe, writes each pixel, then reads one 3x3 window when available.
module line_buffer_window_scheduler #(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS)
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET_N,
  line_buffer_window_scheduler_if.master bus
);

  localparam logic [P_FRAME_COLUMN_BITS-1:0] LAST_COL = P_FRAME_COLUMN_BITS'(P_FRAME_COLUMNS - 1);
  localparam logic [P_FRAME_ROW_BITS-1:0]    LAST_ROW = P_FRAME_ROW_BITS'(P_FRAME_ROWS - 1);
  localparam logic [P_FRAME_COLUMN_BITS-1:0] COL_ONE  = P_FRAME_COLUMN_BITS'(1);
  localparam logic [P_FRAME_COLUMN_BITS-1:0] COL_TWO  = P_FRAME_COLUMN_BITS'(2);
  localparam logic [P_FRAME_ROW_BITS-1:0]    ROW_ONE  = P_FRAME_ROW_BITS'(1);
  localparam logic [P_FRAME_ROW_BITS-1:0]    ROW_TWO  = P_FRAME_ROW_BITS'(2);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_ARMED, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [P_FRAME_COLUMN_BITS-1:0] col_q, col_d;
  logic [P_FRAME_ROW_BITS-1:0]    row_q, row_d;
  logic [1:0]                     slot_q, slot_d;
  logic                           valid_q, valid_d;
  logic [P_FRAME_COLUMN_BITS-1:0] mcol_q, mcol_d;
  logic [P_FRAME_ROW_BITS-1:0]    mrow_q, mrow_d;
  logic                           overrun_q, overrun_d;

  logic       strobe, sof_strobe, col_wrap, last_pixel, has_window;
  logic       do_resync, do_advance;
  logic [1:0] slot_inc;

  assign strobe     = bus.I_PIXEL_STROBE;
  assign sof_strobe = bus.I_PIXEL_STROBE & bus.I_SOF;
  assign col_wrap   = (col_q == LAST_COL);
  assign last_pixel = col_wrap && (row_q == LAST_ROW);
  assign has_window = (col_q >= COL_TWO) && (row_q >= ROW_TWO);
  // Slot after the current one; also the slot holding the row two above the current row.
  assign slot_inc   = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    slot_d     = slot_q;
    valid_d    = 1'b0;
    mcol_d     = mcol_q;
    mrow_d     = mrow_q;
    overrun_d  = overrun_q;
    do_resync  = 1'b0;
    do_advance = 1'b0;
    unique case (state_q)
      S_IDLE: do_resync = sof_strobe;
      S_WRITE: begin
        if (strobe) overrun_d = 1'b1;
        if (has_window)      state_d = S_READ;
        else if (last_pixel) state_d = S_DONE;
        else                 state_d = S_ARMED;
      end
      S_READ: begin
        valid_d = 1'b1;
        mcol_d  = col_q - COL_ONE;
        mrow_d  = row_q - ROW_ONE;
        if (sof_strobe)      do_resync = 1'b1;
        else if (last_pixel) state_d = S_DONE;
        else if (strobe)     do_advance = 1'b1;
        else                 state_d = S_ARMED;
      end
      S_ARMED: begin
        do_resync  = sof_strobe;
        do_advance = strobe & ~bus.I_SOF;
      end
      S_DONE: begin
        if (strobe) overrun_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (do_resync) begin
      col_d   = '0;
      row_d   = '0;
      slot_d  = 2'd0;
      state_d = S_WRITE;
    end else if (do_advance) begin
      state_d = S_WRITE;
      if (col_wrap) begin
        col_d  = '0;
        row_d  = row_q + ROW_ONE;
        slot_d = slot_inc;
      end else begin
        col_d  = col_q + COL_ONE;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      slot_q    <= 2'd0;
      valid_q   <= 1'b0;
      mcol_q    <= '0;
      mrow_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      slot_q    <= slot_d;
      valid_q   <= valid_d;
      mcol_q    <= mcol_d;
      mrow_q    <= mrow_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign bus.O_WRITE_ENABLE  = (state_q == S_WRITE);
  assign bus.O_WRITE_COLUMN  = (state_q == S_WRITE) ? col_q : '0;
  assign bus.O_WRITE_SLOT    = (state_q == S_WRITE) ? slot_q : 2'd0;
  assign bus.O_READ_ENABLE   = (state_q == S_READ);
  assign bus.O_READ_COLUMN   = (state_q == S_READ) ? col_q - COL_TWO : '0;
  assign bus.O_READ_TOP_SLOT = (state_q == S_READ) ? slot_inc : 2'd0;
  assign bus.O_MATRIX_VALID  = valid_q;
  assign bus.O_MATRIX_COLUMN = mcol_q;
  assign bus.O_MATRIX_ROW    = mrow_q;
  assign bus.O_FRAME_DONE    = (state_q == S_DONE);
  assign bus.O_OVERRUN       = overrun_q;

endmodule

// File: tb/tb_line_buffer_window_scheduler.sv
// tb/tb_line_buffer_window_scheduler.sv - directed checks of the window scheduler on an 8x6 frame
module tb_line_buffer_window_scheduler;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CB   = 3;
  localparam int RB   = 3;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   sc[48];
  int   wr_col[$], wr_slot[$], wr_cyc[$];
  int   rd_col[$], rd_slot[$], rd_cyc[$];
  int   vld_col[$], vld_row[$], vld_cyc[$];
  int   done_cyc[$];

  line_buffer_window_scheduler_if #(.COLUMN_BITS(CB), .ROW_BITS(RB)) bus ();

  line_buffer_window_scheduler #(
    .P_FRAME_COLUMNS(COLS),
    .P_FRAME_ROWS(ROWS)
  ) dut (
    .I_CLK(clk),
    .I_RESET_N(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle; cyc is the number of the edge that opened this cycle.
  always @(negedge clk) begin
    if (bus.O_WRITE_ENABLE === 1'b1) begin
      wr_col.push_back(int'(bus.O_WRITE_COLUMN)); wr_slot.push_back(int'(bus.O_WRITE_SLOT)); wr_cyc.push_back(cyc);
    end
    if (bus.O_READ_ENABLE === 1'b1) begin
      rd_col.push_back(int'(bus.O_READ_COLUMN)); rd_slot.push_back(int'(bus.O_READ_TOP_SLOT)); rd_cyc.push_back(cyc);
    end
    if (bus.O_MATRIX_VALID === 1'b1) begin
      vld_col.push_back(int'(bus.O_MATRIX_COLUMN)); vld_row.push_back(int'(bus.O_MATRIX_ROW)); vld_cyc.push_back(cyc);
    end
    if (bus.O_FRAME_DONE === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_col.delete(); wr_slot.delete(); wr_cyc.delete();
    rd_col.delete(); rd_slot.delete(); rd_cyc.delete();
    vld_col.delete(); vld_row.delete(); vld_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic pixel(input logic sof, input int gap, output int scyc);
    bus.I_SOF = sof;
    bus.I_PIXEL_STROBE = 1'b1;
    tick();
    scyc = cyc;
    bus.I_SOF = 1'b0;
    bus.I_PIXEL_STROBE = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic run_frame();
    for (int i = 0; i < COLS * ROWS; i++) pixel(i == 0, 4, sc[i]);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.I_SOF = 1'b1;
    bus.I_PIXEL_STROBE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.I_PIXEL_STROBE = ~bus.I_PIXEL_STROBE;
      tick();
    end
    total++;
    if ({bus.O_WRITE_ENABLE, bus.O_READ_ENABLE, bus.O_MATRIX_VALID, bus.O_FRAME_DONE} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000",
        {bus.O_WRITE_ENABLE, bus.O_READ_ENABLE, bus.O_MATRIX_VALID, bus.O_FRAME_DONE});
    end
    total++;
    if ({bus.O_WRITE_COLUMN, bus.O_WRITE_SLOT, bus.O_READ_COLUMN, bus.O_READ_TOP_SLOT} !== '0) begin
      bad++; $display("FAIL reset_addr got wc=%0d ws=%0d rc=%0d rs=%0d exp all 0",
        bus.O_WRITE_COLUMN, bus.O_WRITE_SLOT, bus.O_READ_COLUMN, bus.O_READ_TOP_SLOT);
    end
    total++;
    if ({bus.O_MATRIX_COLUMN, bus.O_MATRIX_ROW} !== '0) begin
      bad++; $display("FAIL reset_centre got=(%0d,%0d) exp=(0,0)", bus.O_MATRIX_COLUMN, bus.O_MATRIX_ROW);
    end
    total++;
    if (bus.O_OVERRUN !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", bus.O_OVERRUN); end
    bus.I_SOF = 1'b0;
    bus.I_PIXEL_STROBE = 1'b0;
    resetn = 1'b1;
    tick();
    clear_logs();
    for (int i = 0; i < 3; i++) pixel(1'b0, 4, sc[i]);
    total++;
    if (wr_cyc.size() != 0) begin bad++; $display("FAIL idle_no_sof_writes got=%0d exp=0", wr_cyc.size()); end
    total++;
    if (bus.O_OVERRUN !== 1'b0) begin bad++; $display("FAIL idle_overrun got=%b exp=0", bus.O_OVERRUN); end
  endtask

  task automatic test_full_frame();
    int j, c, r;
    clear_logs();
    run_frame();
    total++;
    if (wr_col.size() != 48) begin bad++; $display("FAIL frame_writes got=%0d exp=48", wr_col.size()); end
    else for (int i = 0; i < 48; i++) begin
      c = i % COLS; r = i / COLS;
      total++;
      if (wr_col[i] !== c || wr_slot[i] !== r % 3 || wr_cyc[i] !== sc[i]) begin
        bad++; $display("FAIL frame_write[%0d] got col=%0d slot=%0d cyc=%0d exp col=%0d slot=%0d cyc=%0d",
          i, wr_col[i], wr_slot[i], wr_cyc[i], c, r % 3, sc[i]);
      end
    end
    total++;
    if (vld_col.size() != 24 || rd_col.size() != 24) begin
      bad++; $display("FAIL frame_windows got valids=%0d reads=%0d exp=24", vld_col.size(), rd_col.size());
    end else begin
      j = 0;
      for (int i = 0; i < 48; i++) begin
        c = i % COLS; r = i / COLS;
        if (c >= 2 && r >= 2) begin
          total++;
          if (rd_col[j] !== c - 2 || rd_slot[j] !== (r - 2) % 3 || rd_cyc[j] !== sc[i] + 1) begin
            bad++; $display("FAIL frame_read[%0d] got col=%0d top=%0d cyc=%0d exp col=%0d top=%0d cyc=%0d",
              j, rd_col[j], rd_slot[j], rd_cyc[j], c - 2, (r - 2) % 3, sc[i] + 1);
          end
          total++;
          if (vld_col[j] !== c - 1 || vld_row[j] !== r - 1 || vld_cyc[j] !== sc[i] + 2) begin
            bad++; $display("FAIL frame_valid[%0d] got (%0d,%0d) cyc=%0d exp (%0d,%0d) cyc=%0d",
              j, vld_col[j], vld_row[j], vld_cyc[j], c - 1, r - 1, sc[i] + 2);
          end
          j++;
        end
      end
      total++;
      if (vld_cyc[0] !== sc[18] + 2 || vld_col[0] !== 1 || vld_row[0] !== 1 || rd_slot[0] !== 0) begin
        bad++; $display("FAIL first_window got cyc=%0d (%0d,%0d) top=%0d exp cyc=%0d (1,1) top=0",
          vld_cyc[0], vld_col[0], vld_row[0], rd_slot[0], sc[18] + 2);
      end
      total++;
      if (vld_col[23] !== 6 || vld_row[23] !== 4) begin
        bad++; $display("FAIL last_centre got=(%0d,%0d) exp=(6,4)", vld_col[23], vld_row[23]);
      end
      total++;
      if (rd_col[6] !== 0 || rd_slot[6] !== 1 || vld_col[6] !== 1 || vld_row[6] !== 2) begin
        bad++; $display("FAIL slot_rotation_read got col=%0d top=%0d centre=(%0d,%0d) exp col=0 top=1 centre=(1,2)",
          rd_col[6], rd_slot[6], vld_col[6], vld_row[6]);
      end
    end
    if (wr_slot.size() == 48) begin
      total++;
      if (wr_slot[24] !== 0 || wr_slot[31] !== 0 || wr_slot[32] !== 1) begin
        bad++; $display("FAIL slot_rotation_write got r3=%0d/%0d r4=%0d exp 0/0 1", wr_slot[24], wr_slot[31], wr_slot[32]);
      end
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] !== sc[47] + 2) begin
      bad++; $display("FAIL frame_done got count=%0d cyc=%0d exp count=1 cyc=%0d",
        done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, sc[47] + 2);
    end
  endtask

  task automatic test_overrun();
    int s3, sdrop, s4;
    clear_logs();
    for (int i = 0; i < 3; i++) pixel(i == 0, 4, sc[i]);
    pixel(1'b0, 1, s3);
    pixel(1'b0, 4, sdrop);
    total++;
    if (bus.O_OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", bus.O_OVERRUN); end
    pixel(1'b0, 4, s4);
    repeat (4) tick();
    total++;
    if (wr_col.size() != 5 || wr_col[4] !== 4 || wr_cyc[4] !== s4) begin
      bad++; $display("FAIL overrun_next_col got writes=%0d col=%0d exp writes=5 col=4",
        wr_col.size(), (wr_col.size() > 4) ? wr_col[4] : -1);
    end
    total++;
    if (bus.O_OVERRUN !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b exp=1", bus.O_OVERRUN); end
  endtask

  task automatic test_resync();
    int s29, sr, hits;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    total++;
    if (bus.O_OVERRUN !== 1'b0) begin bad++; $display("FAIL overrun_cleared got=%b exp=0", bus.O_OVERRUN); end
    clear_logs();
    for (int i = 0; i < 29; i++) pixel(i == 0, 4, sc[i]);
    pixel(1'b0, 2, s29);
    pixel(1'b1, 4, sr);
    repeat (3) tick();
    hits = 0;
    for (int i = 0; i < wr_cyc.size(); i++)
      if (wr_cyc[i] == sr && wr_col[i] == 0 && wr_slot[i] == 0) hits++;
    total++;
    if (hits != 1) begin bad++; $display("FAIL resync_write got matches=%0d exp=1 (col 0 slot 0)", hits); end
    hits = 0;
    for (int i = 0; i < vld_cyc.size(); i++)
      if (vld_cyc[i] == s29 + 2 && vld_col[i] == 4 && vld_row[i] == 2) hits++;
    total++;
    if (hits != 1) begin bad++; $display("FAIL resync_pending_valid got matches=%0d exp=1 centre (4,2)", hits); end
    total++;
    if (bus.O_OVERRUN !== 1'b0) begin bad++; $display("FAIL resync_overrun got=%b exp=0", bus.O_OVERRUN); end
  endtask

  task automatic test_midframe_reset();
    int s18;
    for (int i = 0; i < 18; i++) pixel(i == 0, 4, sc[i]);
    pixel(1'b0, 1, s18);
    tick();
    total++;
    if (bus.O_READ_ENABLE !== 1'b1) begin bad++; $display("FAIL midreset_in_read got=%b exp=1", bus.O_READ_ENABLE); end
    resetn = 1'b0;
    tick();
    total++;
    if ({bus.O_MATRIX_VALID, bus.O_WRITE_ENABLE, bus.O_READ_ENABLE, bus.O_FRAME_DONE} !== 4'b0) begin
      bad++; $display("FAIL midreset_outputs got=%b exp=0000",
        {bus.O_MATRIX_VALID, bus.O_WRITE_ENABLE, bus.O_READ_ENABLE, bus.O_FRAME_DONE});
    end
    resetn = 1'b1;
    tick();
    clear_logs();
    run_frame();
    total++;
    if (wr_col.size() != 48 || vld_col.size() != 24 || done_cyc.size() != 1) begin
      bad++; $display("FAIL midreset_frame got writes=%0d valids=%0d done=%0d exp 48/24/1",
        wr_col.size(), vld_col.size(), done_cyc.size());
    end
    total++;
    if (wr_col.size() == 0 || wr_col[0] !== 0 || wr_slot[0] !== 0 || vld_col.size() == 0 ||
        vld_col[0] !== 1 || vld_row[0] !== 1) begin
      bad++; $display("FAIL midreset_first got first write/valid not at col 0 slot 0 / centre (1,1)");
    end
    total++;
    if (bus.O_OVERRUN !== 1'b0) begin bad++; $display("FAIL midreset_overrun got=%b exp=0", bus.O_OVERRUN); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overrun();
    test_resync();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_buffer_window_scheduler.md
Name: line_buffer_window_scheduler

Overview:
- Sequences the 3-row grayscale line buffer that feeds the Sobel stage.
- Per incoming pixel strobe it tracks frame column/row and issues one buffer write (column, rotating row slot).
- Once a full 3x3 neighbourhood exists, it issues one window read and then flags the matrix valid with its centre coordinates.
- Sits between the grayscale converter (1-cycle latency) and frame_buffer_matrix3 (1-cycle read latency); replaces ad-hoc enable toggling with an explicit FSM.

Parameters:
- P_FRAME_COLUMNS, 640, pixels per row.
- P_FRAME_ROWS, 480, rows per frame.
- P_FRAME_COLUMN_BITS, $clog2(P_FRAME_COLUMNS), column index width.
- P_FRAME_ROW_BITS, $clog2(P_FRAME_ROWS), row index width.

Ports:
- I_CLK  in  1  single clock for all logic.
- I_RESET_N  in  1  synchronous, active-low reset.
- I_SOF  in  1  start-of-frame; qualified only together with I_PIXEL_STROBE; marks pixel (0,0).
- I_PIXEL_STROBE  in  1  one-cycle pulse per arriving pixel.
- O_WRITE_ENABLE  out  1  buffer write strobe.
- O_WRITE_COLUMN  out  P_FRAME_COLUMN_BITS  write column.
- O_WRITE_SLOT  out  2  buffer row slot 0..2.
- O_READ_ENABLE  out  1  buffer window-read strobe.
- O_READ_COLUMN  out  P_FRAME_COLUMN_BITS  left column of the window.
- O_READ_TOP_SLOT  out  2  slot holding the window's top row.
- O_MATRIX_VALID  out  1  buffer matrix output valid this cycle.
- O_MATRIX_COLUMN  out  P_FRAME_COLUMN_BITS  window centre column.
- O_MATRIX_ROW  out  P_FRAME_ROW_BITS  window centre row.
- O_FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is handled.
- O_OVERRUN  out  1  sticky; a strobe was dropped.

Behaviour:
- Reset (I_RESET_N=0 at posedge): all outputs 0, column/row counters 0, slot 0, O_OVERRUN cleared, FSM=IDLE. Applies mid-frame; any in-flight write/read is abandoned.
- FSM states:
  - IDLE: wait for I_SOF & I_PIXEL_STROBE. On it, latch column 0, row 0, slot 0; go to WRITE. Strobes without I_SOF are ignored, no overrun.
  - WRITE (1 cycle): O_WRITE_ENABLE=1 with the latched column/slot.
    - If column>=2 and row>=2, go to READ.
    - Else, if the pixel was the last of the frame, go to DONE; otherwise go to ARMED.
  - READ (1 cycle): O_READ_ENABLE=1, O_READ_COLUMN=column-2, O_READ_TOP_SLOT=(slot+1) mod 3.
    - The centre (column-1, row-1) is registered; the next cycle O_MATRIX_VALID=1 with those coordinates, regardless of the next state.
    - Next state: DONE if last pixel, else ARMED, or WRITE if a strobe was captured this cycle.
  - ARMED: a strobe advances the counters and goes to WRITE.
  - DONE (1 cycle): O_FRAME_DONE=1, then IDLE.
- Counter advance on an accepted strobe:
  - column+1.
  - At P_FRAME_COLUMNS-1, column wraps to 0, row+1, slot=(slot+1) mod 3 (slot never equals 3).
  - Last pixel = column P_FRAME_COLUMNS-1 and row P_FRAME_ROWS-1.
- Strobe acceptance:
  - Accepted in ARMED and READ.
  - A strobe in WRITE or DONE is dropped: counters unchanged, O_OVERRUN set until reset.
  - Minimum strobe spacing is therefore 2 cycles.
- I_SOF with a strobe in ARMED or READ: resync. Counters forced to (0,0), slot 0, go to WRITE; a pending O_MATRIX_VALID still fires; no overrun.
- Windows per frame: (P_FRAME_COLUMNS-2)*(P_FRAME_ROWS-2). Centres cover columns 1..P_FRAME_COLUMNS-2 and rows 1..P_FRAME_ROWS-2. No border windows.
- Latency: strobe at cycle t gives write at t+1, read at t+2 (if window), valid at t+3.
- All outputs registered; no combinational input-to-output paths.

Test Plan:
- Reset: hold I_RESET_N=0 for 3 cycles with strobes toggling -> all outputs 0, O_OVERRUN=0; release -> IDLE, strobes without I_SOF produce no write.
- Full small frame (P_FRAME_COLUMNS=8, P_FRAME_ROWS=6, strobe every 4 cycles, I_SOF on first):
  - 48 writes; first O_MATRIX_VALID 3 cycles after the 19th strobe with centre (1,1), O_READ_TOP_SLOT=0.
  - 24 valids in total; last centre (6,4).
  - O_FRAME_DONE 3 cycles after the 48th strobe.
- Slot rotation (8x6): row 3 writes go to slot 0; the window read at (col 2,row 3) has O_READ_TOP_SLOT=1 and centre (1,2). Row 4 writes go to slot 1.
- Overrun: strobes on consecutive cycles at pixel (3,0) -> second strobe dropped, O_OVERRUN=1 and sticky, next accepted strobe writes column 4 (not 5).
- Resync: I_SOF+strobe at pixel (5,3) -> write column 0 / slot 0; the pending valid for centre (4,2) still asserts; no overrun.
- Mid-frame reset during a READ cycle -> the following cycle O_MATRIX_VALID=0 and all counters 0; the next I_SOF frame runs cleanly with 24 valids.
